cartoon_gen: RTL and testbench



---
 rtl/cartoon_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_cartoon_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cartoon_gen.sv
// cartoon_gen: draws a bouncing cartoon face with blinking eyes.
// The face square moves STEP pixels per axis once per frame and bounces
// off the 640x480 visible area. The eyes open and close on a frame-tick timer.
// Colour output is registered. It appears one cycle after the pixel
// coordinates that produced it.
module cartoon_gen #(
  parameter int SIZE         = 32,
  parameter int STEP         = 2,
  parameter int BLINK_OPEN   = 120,
  parameter int BLINK_CLOSED = 8,
  parameter int X0           = 100,
  parameter int Y0           = 50
) (
  input  logic       clock_25MHz,
  input  logic       reset,
  input  logic [9:0] pixel_row,
  input  logic [9:0] pixel_col,
  input  logic       freeze,
  output logic       red,
  output logic       green,
  output logic       blue
);

  typedef enum logic {
    OPEN   = 1'b0,
    CLOSED = 1'b1
  } blink_t;

  // Motion arithmetic uses 11 bits, so x+STEP+SIZE never wraps.
  localparam logic [10:0] SIZE11      = 11'(SIZE);
  localparam logic [10:0] STEP11      = 11'(STEP);
  localparam logic [10:0] X_LIMIT     = 11'd640;
  localparam logic [10:0] Y_LIMIT     = 11'd480;
  localparam logic [7:0]  OPEN_LAST   = 8'(BLINK_OPEN - 1);
  localparam logic [7:0]  CLOSED_LAST = 8'(BLINK_CLOSED - 1);

  // Face position, travel direction (0 = right/down), and blink state.
  logic [9:0] x;
  logic [9:0] y;
  logic       dir_x;
  logic       dir_y;
  blink_t     blink_state;
  logic [7:0] blink_cnt;
  logic       eyes_closed;

  // Frame-tick detection: one pulse on entry to (480, 0).
  logic       at_tick_pos;
  logic       prev_at;
  logic       tick;
  logic       advance;

  assign at_tick_pos = (pixel_row == 10'd480) && (pixel_col == 10'd0);
  assign tick        = at_tick_pos && !prev_at;
  assign advance     = tick && !freeze;
  assign eyes_closed = (blink_state == CLOSED);

  // Remember whether the previous cycle was already at (480, 0).
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      prev_at <= 1'b0;
    end else begin
      prev_at <= at_tick_pos;
    end
  end

  // Next position and direction per axis, computed in 11-bit space.
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        dir_x_next;
  logic        dir_y_next;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  // Horizontal bounce: clamp at the right edge or at column 0, and reverse.
  always_comb begin
    x_next     = x;
    dir_x_next = dir_x;
    if (!dir_x) begin
      if (x_ext + STEP11 + SIZE11 > X_LIMIT) begin
        x_next     = 10'(X_LIMIT - SIZE11);
        dir_x_next = 1'b1;
      end else begin
        x_next = 10'(x_ext + STEP11);
      end
    end else begin
      if (x_ext < STEP11) begin
        x_next     = 10'd0;
        dir_x_next = 1'b0;
      end else begin
        x_next = 10'(x_ext - STEP11);
      end
    end
  end

  // Vertical bounce: same rule as horizontal, with a 480-row limit.
  always_comb begin
    y_next     = y;
    dir_y_next = dir_y;
    if (!dir_y) begin
      if (y_ext + STEP11 + SIZE11 > Y_LIMIT) begin
        y_next     = 10'(Y_LIMIT - SIZE11);
        dir_y_next = 1'b1;
      end else begin
        y_next = 10'(y_ext + STEP11);
      end
    end else begin
      if (y_ext < STEP11) begin
        y_next     = 10'd0;
        dir_y_next = 1'b0;
      end else begin
        y_next = 10'(y_ext - STEP11);
      end
    end
  end

  // Update position once per unfrozen frame tick.
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      x     <= 10'(X0);
      y     <= 10'(Y0);
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else if (advance) begin
      x     <= x_next;
      y     <= y_next;
      dir_x <= dir_x_next;
      dir_y <= dir_y_next;
    end
  end

  // Blink FSM: count frame ticks in each state, then swap states.
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      blink_state <= OPEN;
      blink_cnt   <= 8'd0;
    end else if (advance) begin
      case (blink_state)
        OPEN: begin
          if (blink_cnt == OPEN_LAST) begin
            blink_state <= CLOSED;
            blink_cnt   <= 8'd0;
          end else begin
            blink_cnt <= blink_cnt + 8'd1;
          end
        end
        CLOSED: begin
          if (blink_cnt == CLOSED_LAST) begin
            blink_state <= OPEN;
            blink_cnt   <= 8'd0;
          end else begin
            blink_cnt <= blink_cnt + 8'd1;
          end
        end
        default: begin
          blink_state <= OPEN;
          blink_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Pixel classification relative to the face's current top-left corner.
  logic [10:0] row_ext;
  logic [10:0] col_ext;
  logic [10:0] dr;
  logic [10:0] dc;
  logic        off_screen;
  logic        in_face;
  logic        eye;
  logic        mouth;
  logic [2:0]  rgb_next;

  assign row_ext    = {1'b0, pixel_row};
  assign col_ext    = {1'b0, pixel_col};
  assign dr         = row_ext - y_ext;
  assign dc         = col_ext - x_ext;
  assign off_screen = (pixel_row > 10'd479) || (pixel_col > 10'd639);
  assign in_face    = (row_ext >= y_ext) && (row_ext < y_ext + SIZE11) &&
                      (col_ext >= x_ext) && (col_ext < x_ext + SIZE11);
  assign eye        = (dr >= 11'd8) && (dr <= 11'd11) &&
                      (((dc >= 11'd8) && (dc <= 11'd11)) ||
                       ((dc >= 11'd20) && (dc <= 11'd23)));
  assign mouth      = (dr >= 11'd22) && (dr <= 11'd23) &&
                      (dc >= 11'd8) && (dc <= 11'd23);

  // Colour priority: off-screen, background, eyes, mouth, face.
  // Closed eyes show only a single dark line on row 10.
  always_comb begin
    rgb_next = 3'b110;
    if (off_screen) begin
      rgb_next = 3'b000;
    end else if (!in_face) begin
      rgb_next = 3'b001;
    end else if (eye) begin
      if (!eyes_closed || (dr == 11'd10)) begin
        rgb_next = 3'b000;
      end else begin
        rgb_next = 3'b110;
      end
    end else if (mouth) begin
      rgb_next = 3'b100;
    end else begin
      rgb_next = 3'b110;
    end
  end

  // Register the colour so it is aligned one cycle after its pixel.
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      red   <= rgb_next[2];
      green <= rgb_next[1];
      blue  <= rgb_next[0];
    end
  end

endmodule

// File: tb/tb_cartoon_gen.sv
// Testbench for cartoon_gen: directed tables and sequences, then random
// pixels, ticks, freezes and resets compared against a behavioural model.
module tb_cartoon_gen;

  localparam int SIZE   = 32;
  localparam int STEP   = 2;
  localparam int B_OPEN = 120;
  localparam int B_CLS  = 8;

  logic       clk;
  logic       reset;
  logic [9:0] pixel_row;
  logic [9:0] pixel_col;
  logic       freeze;
  logic       red, green, blue;
  logic       red0, green0, blue0;
  logic [2:0] rgb;
  logic [2:0] rgb0;

  int checks   = 0;
  int failures = 0;

  assign rgb  = {red, green, blue};
  assign rgb0 = {red0, green0, blue0};

  cartoon_gen dut (
    .clock_25MHz (clk),
    .reset       (reset),
    .pixel_row   (pixel_row),
    .pixel_col   (pixel_col),
    .freeze      (freeze),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  cartoon_gen #(.STEP(0)) dut0 (
    .clock_25MHz (clk),
    .reset       (reset),
    .pixel_row   (pixel_row),
    .pixel_col   (pixel_col),
    .freeze      (freeze),
    .red         (red0),
    .green       (green0),
    .blue        (blue0)
  );

  // Clock and input defaults.
  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    pixel_row = 10'd0;
    pixel_col = 10'd0;
    freeze    = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply inputs for one clock, then settle past the edge.
  task automatic drive(input int r, input int c, input logic f, input logic rst);
    pixel_row = 10'(r);
    pixel_col = 10'(c);
    freeze    = f;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic f);
    drive(480, 0, f, 1'b0);
    drive(0, 0, f, 1'b0);
  endtask

  task automatic do_ticks(input int n, input logic f);
    for (int i = 0; i < n; i++) do_tick(f);
  endtask

  task automatic do_reset();
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural reference model of the face.
  int m_x, m_y, m_dx, m_dy, m_closed, m_cnt, m_prev_at;

  task automatic model_reset();
    m_x = 100; m_y = 50; m_dx = 0; m_dy = 0;
    m_closed = 0; m_cnt = 0; m_prev_at = 0;
  endtask

  task automatic model_axis(inout int pos, inout int dir, input int limit);
    if (dir == 0) begin
      if (pos + STEP + SIZE > limit) begin pos = limit - SIZE; dir = 1; end
      else pos = pos + STEP;
    end else begin
      if (pos < STEP) begin pos = 0; dir = 0; end
      else pos = pos - STEP;
    end
  endtask

  task automatic model_frame();
    model_axis(m_x, m_dx, 640);
    model_axis(m_y, m_dy, 480);
    m_cnt++;
    if (m_closed == 0 && m_cnt == B_OPEN) begin m_closed = 1; m_cnt = 0; end
    else if (m_closed == 1 && m_cnt == B_CLS) begin m_closed = 0; m_cnt = 0; end
  endtask

  function automatic logic [2:0] model_rgb(input int r, input int c);
    int dr, dc;
    logic is_eye;
    if (r > 479 || c > 639) return 3'b000;
    dr = r - m_y;
    dc = c - m_x;
    if (dr < 0 || dr >= SIZE || dc < 0 || dc >= SIZE) return 3'b001;
    is_eye = (dr >= 8 && dr <= 11) && ((dc >= 8 && dc <= 11) || (dc >= 20 && dc <= 23));
    if (is_eye && (m_closed == 0 || dr == 10)) return 3'b000;
    if (is_eye) return 3'b110;
    if (dr >= 22 && dr <= 23 && dc >= 8 && dc <= 23) return 3'b100;
    return 3'b110;
  endfunction

  typedef struct {
    int         row;
    int         col;
    logic [2:0] rgb;
  } vec_t;

  vec_t vecs[14];

  // Main test sequence.
  initial begin
    vecs[0]  = '{50, 100, 3'b110};
    vecs[1]  = '{50, 99, 3'b001};
    vecs[2]  = '{100, 700, 3'b000};
    vecs[3]  = '{49, 100, 3'b001};
    vecs[4]  = '{81, 131, 3'b110};
    vecs[5]  = '{82, 100, 3'b001};
    vecs[6]  = '{50, 132, 3'b001};
    vecs[7]  = '{58, 108, 3'b000};
    vecs[8]  = '{61, 123, 3'b000};
    vecs[9]  = '{58, 112, 3'b110};
    vecs[10] = '{72, 110, 3'b100};
    vecs[11] = '{73, 123, 3'b100};
    vecs[12] = '{72, 124, 3'b110};
    vecs[13] = '{480, 5, 3'b000};

    do_reset();
    check("reset_rgb", 32'(rgb), 0);
    check("reset_x", 32'(dut.x), 100);
    check("reset_y", 32'(dut.y), 50);
    check("reset_dir_x", 32'(dut.dir_x), 0);
    check("reset_dir_y", 32'(dut.dir_y), 0);
    check("reset_closed", 32'(dut.eyes_closed), 0);
    check("reset_cnt", 32'(dut.blink_cnt), 0);

    drive(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].row, vecs[i].col, 1'b0, 1'b0);
      check($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].rgb));
    end

    // One tick on entry to (480, 0); holding it gives no further ticks.
    drive(480, 0, 1'b0, 1'b0);
    check("first_tick_x", 32'(dut.x), 102);
    check("first_tick_y", 32'(dut.y), 52);
    for (int i = 0; i < 3; i++) drive(480, 0, 1'b0, 1'b0);
    check("hold_x", 32'(dut.x), 102);
    check("hold_y", 32'(dut.y), 52);
    drive(0, 0, 1'b0, 1'b0);

    // Right-edge bounce.
    do_reset();
    do_ticks(253, 1'b0);
    check("xb_pre", 32'(dut.x), 606);
    do_tick(1'b0);
    check("xb_1", 32'(dut.x), 608);
    check("xb_1_dir", 32'(dut.dir_x), 0);
    do_tick(1'b0);
    check("xb_2", 32'(dut.x), 608);
    check("xb_2_dir", 32'(dut.dir_x), 1);
    do_tick(1'b0);
    check("xb_3", 32'(dut.x), 606);

    // Bottom-edge bounce.
    do_reset();
    do_ticks(198, 1'b0);
    check("yb_pre", 32'(dut.y), 446);
    do_tick(1'b0);
    check("yb_1", 32'(dut.y), 448);
    do_tick(1'b0);
    check("yb_2", 32'(dut.y), 448);
    check("yb_2_dir", 32'(dut.dir_y), 1);
    do_tick(1'b0);
    check("yb_3", 32'(dut.y), 446);

    // Blink timing on the stationary instance.
    do_reset();
    do_ticks(119, 1'b0);
    drive(58, 109, 1'b0, 1'b0);
    check("blink_open_119", 32'(rgb0), 0);
    do_tick(1'b0);
    drive(60, 109, 1'b0, 1'b0);
    check("blink_closed_r10", 32'(rgb0), 0);
    drive(58, 109, 1'b0, 1'b0);
    check("blink_closed_r8", 32'(rgb0), 32'(3'b110));
    drive(61, 121, 1'b0, 1'b0);
    check("blink_closed_r11", 32'(rgb0), 32'(3'b110));
    do_ticks(7, 1'b0);
    drive(58, 109, 1'b0, 1'b0);
    check("blink_closed_127", 32'(rgb0), 32'(3'b110));
    do_tick(1'b0);
    drive(58, 109, 1'b0, 1'b0);
    check("blink_reopen", 32'(rgb0), 0);

    // Freeze holds all state while the face is still drawn.
    do_reset();
    do_ticks(5, 1'b0);
    do_ticks(10, 1'b1);
    check("freeze_x", 32'(dut.x), 110);
    check("freeze_y", 32'(dut.y), 60);
    check("freeze_cnt", 32'(dut.blink_cnt), 5);
    drive(60, 110, 1'b1, 1'b0);
    check("freeze_draw", 32'(rgb), 32'(3'b110));
    do_tick(1'b0);
    check("unfreeze_x", 32'(dut.x), 112);
    check("unfreeze_y", 32'(dut.y), 62);
    check("unfreeze_cnt", 32'(dut.blink_cnt), 6);

    // Reset on a tick cycle wins over the tick.
    do_reset();
    do_ticks(50, 1'b0);
    drive(480, 0, 1'b0, 1'b1);
    check("rst_tick_x", 32'(dut.x), 100);
    check("rst_tick_y", 32'(dut.y), 50);
    check("rst_tick_closed", 32'(dut.eyes_closed), 0);
    check("rst_tick_cnt", 32'(dut.blink_cnt), 0);
    check("rst_tick_rgb", 32'(rgb), 0);

    // Random traffic against the model.
    drive(0, 0, 1'b0, 1'b1);
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      int r, c, sel;
      logic f, rst, at;
      logic [2:0] exp_rgb;
      sel = int'($urandom_range(0, 99));
      if (sel < 30) begin
        r = 480; c = 0;
      end else if (sel < 40) begin
        r = int'($urandom_range(0, 1023));
        c = int'($urandom_range(0, 1023));
      end else begin
        r = m_y - 4 + int'($urandom_range(0, 40));
        c = m_x - 4 + int'($urandom_range(0, 40));
        if (r < 0) r = 0;
        if (c < 0) c = 0;
      end
      f   = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        exp_rgb = 3'b000;
        model_reset();
      end else begin
        exp_rgb = model_rgb(r, c);
        at = (r == 480 && c == 0);
        if (at && m_prev_at == 0 && !f) model_frame();
        m_prev_at = at ? 1 : 0;
      end
      drive(r, c, f, rst);
      check("rand_rgb", 32'(rgb), 32'(exp_rgb));
      check("rand_x", 32'(dut.x), 32'(m_x));
      check("rand_y", 32'(dut.y), 32'(m_y));
      check("rand_closed", 32'(dut.eyes_closed), 32'(m_closed));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
